cordic_iter_ctrl: RTL and testbench
===================================

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter: BIT_WIDTH, default 32, width of the datapath and of the arctangent table entries.
REQ-002 Parameter: ITERATIONS, default 32, number of micro-rotations per operation; legal range 1..32.
REQ-003 Parameter: INPUT_WIDTH, default $clog2(ITERATIONS), width of the table index.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 x_in, y_in  input  BIT_WIDTH each  signed vector components.
REQ-009 z_in  input  BIT_WIDTH+2  signed angle; 2^32 units per radian at default width.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 x_out, y_out, z_out  output  BIT_WIDTH+2 each  signed results.

Function
REQ-013 States: IDLE, BUSY, DONE; only these three are reachable.
REQ-014 in_ready SHALL be 1 only in IDLE; a transfer occurs on in_valid && in_ready.
REQ-015 On transfer: register x_in/y_in sign-extended to BIT_WIDTH+2, register z_in, clear the iteration counter i to 0, and go to BUSY.
REQ-016 In BUSY, one micro-rotation per cycle, using table entry i from the arctangent sub-module:
- x' = x - d*(y>>>i)
- y' = y + d*(x>>>i)
- z' = z - d*atan[i]
REQ-017 The table entry SHALL be zero-extended to BIT_WIDTH+2 before subtraction.
REQ-018 Shifts SHALL be arithmetic; all adds wrap modulo 2^(BIT_WIDTH+2); no saturation.
REQ-019 Rotation mode: d = +1 when z >= 0, else -1.
REQ-020 After the step with i = ITERATIONS-1, go to DONE; latency is ITERATIONS cycles from the accept edge to out_valid high.
REQ-021 out_valid SHALL be 1 only in DONE; outputs are held stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, return to IDLE. A new operand is accepted no earlier than the following cycle, so throughput is one result per ITERATIONS+2 cycles.
REQ-023 in_valid in BUSY or DONE is ignored, with no state change.
REQ-024 The x_out, y_out and z_out ports SHALL reflect the working registers and are only meaningful while out_valid is 1.

Reset
REQ-025 Reset SHALL take priority over all other inputs in the same cycle.
REQ-026 Reset from any state, including mid-BUSY, SHALL:
- go to IDLE
- set in_ready to 1 and out_valid to 0
- set i, x_out, y_out and z_out to 0
- discard any in-flight operation

Configuration
REQ-027 Macro CORDIC_VECTOR_MODE_EN:
- When defined, add input port mode_in (1 bit) and register it on transfer.
- mode_in = 1 selects vectoring: d = +1 when y < 0, else -1.
- mode_in = 0 selects rotation.
REQ-028 When CORDIC_VECTOR_MODE_EN is undefined, port mode_in SHALL be absent and rotation mode is fixed.

Structure
REQ-029 Package cordic_pkg SHALL hold:
- the state enum typedef (IDLE/BUSY/DONE)
- the constants CORDIC_BIT_WIDTH = 32 and CORDIC_MAX_ITERATIONS = 32
- the gain constant CORDIC_INV_GAIN = 652032874 (1/K * 2^30)
REQ-030 Exactly one sub-module SHALL be used: the existing arctangent lookup cordic_lut, with BIT_WIDTH and INPUT_WIDTH passed through and index driven by i.

Verification
REQ-031 x_in=652032874, y_in=0, z_in=0 -> after 32 cycles out_valid=1; x_out=1073741824±8, y_out=0±8, z_out=0±8.
REQ-032 x_in=652032874, y_in=0, z_in=3373259426 (pi/4) -> x_out and y_out each 759250125±16, z_out=0±8.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is ignored; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-034 Assert reset on BUSY cycle 5 -> next cycle IDLE, in_ready=1, out_valid=0; a fresh operand then completes normally with correct results.
REQ-035 With CORDIC_VECTOR_MODE_EN defined, mode_in=1, x_in=1073741824, y_in=1073741824, z_in=0 -> z_out=3373259426±16, y_out=0±16, x_out=2500605863±64.
REQ-036 Back-to-back operands with in_valid held high -> accept edges are exactly 34 cycles apart and every result matches the reference model.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared state encoding and constants for the CORDIC iteration controller
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CORDIC_BIT_WIDTH      = 32;
    localparam int CORDIC_MAX_ITERATIONS = 32;

    // 1/K scaled by 2^30; pre-scaling x by this yields a unit-gain rotation.
    localparam logic [31:0] CORDIC_INV_GAIN = 32'd652032874;

endpackage

// File: rtl/cordic_lut.sv
// rtl/cordic_lut.sv - arctangent table, atan(2^-index) at 2^BIT_WIDTH units per radian
module cordic_lut #(
    parameter int BIT_WIDTH   = 32,
    parameter int INPUT_WIDTH = 5
) (
    input  logic [INPUT_WIDTH-1:0] index,
    output logic [BIT_WIDTH-1:0]   atan
);

    // Entries are stored at 32-bit scale and rescaled for other widths.
    localparam int UP = (BIT_WIDTH >= 32) ? BIT_WIDTH - 32 : 0;
    localparam int DN = (BIT_WIDTH <  32) ? 32 - BIT_WIDTH : 0;

    logic [31:0] base;
    logic [63:0] wide;

    always_comb begin
        base = 32'd0;
        case (32'(index))
            0:  base = 32'd3373259426;
            1:  base = 32'd1991351318;
            2:  base = 32'd1052175346;
            3:  base = 32'd534100635;
            4:  base = 32'd268086748;
            5:  base = 32'd134174063;
            6:  base = 32'd67103403;
            7:  base = 32'd33553749;
            8:  base = 32'd16777131;
            9:  base = 32'd8388597;
            10: base = 32'd4194303;
            11: base = 32'd2097152;
            12: base = 32'd1048576;
            13: base = 32'd524288;
            14: base = 32'd262144;
            15: base = 32'd131072;
            16: base = 32'd65536;
            17: base = 32'd32768;
            18: base = 32'd16384;
            19: base = 32'd8192;
            20: base = 32'd4096;
            21: base = 32'd2048;
            22: base = 32'd1024;
            23: base = 32'd512;
            24: base = 32'd256;
            25: base = 32'd128;
            26: base = 32'd64;
            27: base = 32'd32;
            28: base = 32'd16;
            29: base = 32'd8;
            30: base = 32'd4;
            31: base = 32'd2;
            default: base = 32'd0;
        endcase
        wide = ({32'd0, base} << UP) >> DN;
        atan = wide[BIT_WIDTH-1:0];
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iterative CORDIC, one micro-rotation per cycle; CORDIC_VECTOR_MODE_EN adds mode_in
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH   = CORDIC_BIT_WIDTH,
    parameter int ITERATIONS  = CORDIC_MAX_ITERATIONS,
    parameter int INPUT_WIDTH = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   x_in,
    input  logic [BIT_WIDTH-1:0]   y_in,
    input  logic [BIT_WIDTH+1:0]   z_in,
`ifdef CORDIC_VECTOR_MODE_EN
    input  logic                   mode_in,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIT_WIDTH+1:0]   x_out,
    output logic [BIT_WIDTH+1:0]   y_out,
    output logic [BIT_WIDTH+1:0]   z_out
);

    localparam int W = BIT_WIDTH + 2;
    localparam logic [INPUT_WIDTH-1:0] LAST = INPUT_WIDTH'(ITERATIONS - 1);

    state_t                  state;
    logic [INPUT_WIDTH-1:0]  i;
    logic signed [W-1:0]     x, y, z;
    logic [BIT_WIDTH-1:0]    atan_raw;
    logic signed [W-1:0]     atan_ext, x_shr, y_shr;
    logic                    d_pos;
`ifdef CORDIC_VECTOR_MODE_EN
    logic                    mode;
`endif

    cordic_lut #(
        .BIT_WIDTH  (BIT_WIDTH),
        .INPUT_WIDTH(INPUT_WIDTH)
    ) u_lut (
        .index(i),
        .atan (atan_raw)
    );

    always_comb begin
        atan_ext = {2'b00, atan_raw};
        x_shr    = x >>> i;
        y_shr    = y >>> i;
`ifdef CORDIC_VECTOR_MODE_EN
        // Vectoring drives y toward zero; rotation drives z toward zero.
        d_pos    = mode ? y[W-1] : ~z[W-1];
`else
        d_pos    = ~z[W-1];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            i         <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
`ifdef CORDIC_VECTOR_MODE_EN
            mode      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= {{2{x_in[BIT_WIDTH-1]}}, x_in};
                        y        <= {{2{y_in[BIT_WIDTH-1]}}, y_in};
                        z        <= z_in;
                        i        <= '0;
`ifdef CORDIC_VECTOR_MODE_EN
                        mode     <= mode_in;
`endif
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (d_pos) begin
                        x <= x - y_shr;
                        y <= y + x_shr;
                        z <= z - atan_ext;
                    end else begin
                        x <= x + y_shr;
                        y <= y - x_shr;
                        z <= z + atan_ext;
                    end
                    if (i == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign x_out = x;
    assign y_out = y;
    assign z_out = z;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb/tb_cordic_iter_ctrl.sv - randomized self-checking bench against a real-arithmetic CORDIC model
module tb_cordic_iter_ctrl;

    localparam int BW = 32;
    localparam int IT = 32;
    localparam int W  = BW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] x_in, y_in;
    logic [W-1:0]  z_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  x_out, y_out, z_out;
`ifdef CORDIC_VECTOR_MODE_EN
    logic          mode;
`endif

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    real    kgain;

    cordic_iter_ctrl #(
        .BIT_WIDTH (BW),
        .ITERATIONS(IT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
`ifdef CORDIC_VECTOR_MODE_EN
        .mode_in  (mode),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Ideal rotation/vectoring scaled by the CORDIC gain.
    task automatic model(input longint x, input longint y, input longint z, input bit m,
                         output longint ex, output longint ey, output longint ez);
        real a, rx, ry;
        a  = real'(z) / (2.0 ** BW);
        rx = real'(x);
        ry = real'(y);
        if (m) begin
            ex = longint'(kgain * $sqrt(rx * rx + ry * ry));
            ey = 0;
            ez = longint'(real'(z) + $atan2(ry, rx) * (2.0 ** BW));
        end else begin
            ex = longint'(kgain * (rx * $cos(a) - ry * $sin(a)));
            ey = longint'(kgain * (ry * $cos(a) + rx * $sin(a)));
            ez = 0;
        end
    endtask

    task automatic drive(input longint x, input longint y, input longint z, input bit m);
        x_in = x[BW-1:0];
        y_in = y[BW-1:0];
        z_in = z[W-1:0];
`ifdef CORDIC_VECTOR_MODE_EN
        mode = m;
`else
        if (m) $display("vector mode requested in rotation-only build");
`endif
    endtask

    task automatic start_op(input longint x, input longint y, input longint z, input bit m);
        for (int k = 0; k < 100 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        drive(x, y, z, m);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input longint x, input longint y, input longint z,
                                input bit m, input longint txy, input longint tz);
        longint ex, ey, ez;
        model(x, y, z, m, ex, ey, ez);
        check({tag, "_x"}, sx(x_out), ex, txy);
        check({tag, "_y"}, sx(y_out), ey, txy);
        check({tag, "_z"}, sx(z_out), ez, tz);
    endtask

    task automatic run_op(input string tag, input longint x, input longint y, input longint z,
                          input bit m, input longint txy, input longint tz);
        int lat;
        start_op(x, y, z, m);
        wait_done(lat);
        check({tag, "_lat"}, longint'(lat), IT, 0);
        check_result(tag, x, y, z, m, txy, tz);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic longint rnd_xy();
        return longint'($urandom_range(0, 32'h4000_0000)) - 64'sd536870912;
    endfunction

    function automatic longint rnd_z();
        return longint'($urandom_range(0, 1000000000)) * 12 - 64'sd6000000000;
    endfunction

    initial begin
        longint ox, oy, oz;
        longint opx[5], opy[5], opz[5];
        longint acc_t[$];
        int     exp_q[$];
        int     lat, nacc, nres, idx;
        bit     stable;
        int     nready;

        kgain = 1.0;
        for (int k = 0; k < IT; k++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * k));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", longint'(in_ready), 1, 0);
        check("rst_out_valid", longint'(out_valid), 0, 0);
        check("rst_x", sx(x_out), 0, 0);
        check("rst_y", sx(y_out), 0, 0);
        check("rst_z", sx(z_out), 0, 0);

        run_op("unit", 652032874, 0, 0, 1'b0, 8, 8);
        check("unit_abs_x", sx(x_out), 1073741824, 8);

        // Result held under backpressure; a second operand is ignored.
        start_op(652032874, 0, 64'sd3373259426, 1'b0);
        wait_done(lat);
        check("pi4_lat", longint'(lat), IT, 0);
        check_result("pi4", 652032874, 0, 64'sd3373259426, 1'b0, 16, 8);
        check("pi4_abs_y", sx(y_out), 759250125, 16);
        ox = sx(x_out); oy = sx(y_out); oz = sx(z_out);
        drive(123456, -654321, 1000, 1'b0);
        in_valid = 1'b1;
        stable = 1'b1; nready = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!out_valid || sx(x_out) != ox || sx(y_out) != oy || sx(z_out) != oz) stable = 1'b0;
            if (in_ready) nready++;
        end
        check("hold_stable", longint'(stable), 1, 0);
        check("hold_in_ready", longint'(nready), 0, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", longint'(in_ready), 1, 0);
        check("release_out_valid", longint'(out_valid), 0, 0);
        check("release_x_kept", sx(x_out), ox, 0);

        // Reset mid-BUSY discards the operation.
        start_op(400000000, 300000000, 100000000, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_in_ready", longint'(in_ready), 1, 0);
        check("midrst_out_valid", longint'(out_valid), 0, 0);
        check("midrst_x", sx(x_out), 0, 0);
        check("midrst_y", sx(y_out), 0, 0);
        check("midrst_z", sx(z_out), 0, 0);
        run_op("after_rst", 652032874, 0, 64'sd3373259426, 1'b0, 16, 8);

`ifdef CORDIC_VECTOR_MODE_EN
        run_op("vec", 1073741824, 1073741824, 0, 1'b1, 64, 16);
        check("vec_abs_z", sx(z_out), 64'sd3373259426, 16);
        check("vec_abs_x", sx(x_out), 64'sd2500605863, 64);
`endif

        for (int k = 0; k < 6; k++)
            run_op("rand", rnd_xy(), rnd_xy(), rnd_z(), 1'b0, 64, 16);

        // Back-to-back with in_valid held high and the consumer always ready.
        for (int k = 0; k < 5; k++) begin
            opx[k] = rnd_xy(); opy[k] = rnd_xy(); opz[k] = rnd_z();
        end
        out_ready = 1'b1;
        drive(opx[0], opy[0], opz[0], 1'b0);
        in_valid = 1'b1;
        nacc = 0; nres = 0;
        for (int c = 0; c < 1000 && nres < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                idx = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                check_result("b2b", opx[idx], opy[idx], opz[idx], 1'b0, 64, 16);
                nres++;
            end
            if (in_valid && in_ready) begin
                acc_t.push_back(cyc);
                exp_q.push_back(nacc);
                nacc++;
                @(posedge clk); #1;
                if (nacc < 5) drive(opx[nacc], opy[nacc], opz[nacc], 1'b0);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", longint'(nres), 5, 0);
        for (int k = 1; k < acc_t.size(); k++)
            check("b2b_gap", acc_t[k] - acc_t[k-1], IT + 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
